// File: rtl/div_pkg.sv
// div_pkg: FSM state encoding and response status codes shared by the divider sequencer and controller.
package div_pkg;

    localparam int WD_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_RUN,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK  = 2'b00,
        ERR_DVZ = 2'b01,
        ERR_OVF = 2'b10,
        ERR_TMO = 2'b11
    } err_t;

    // Divider stopped without a result: overflow wins, then divide-by-zero, otherwise overflow.
    function automatic err_t fail_code(input logic ovf, input logic dvz);
        return (dvz && !ovf) ? ERR_DVZ : ERR_OVF;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: request, divider-control and response signals of the divider sequencer.
interface div_seq_if #(parameter int W = 10);
    import div_pkg::*;

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;

    logic         div_start;
    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic         div_busy;
    logic         div_valid;
    logic         div_dvz;
    logic         div_ovf;
    logic [W-1:0] div_q;
    logic [W-1:0] div_r;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_q;
    logic [W-1:0] rsp_r;
    err_t         rsp_err;

    modport slave (
        input  req_valid, req_a, req_b,
        input  div_busy, div_valid, div_dvz, div_ovf, div_q, div_r,
        input  rsp_ready,
        output req_ready, div_start, div_a, div_b,
        output rsp_valid, rsp_q, rsp_r, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b,
        output div_busy, div_valid, div_dvz, div_ovf, div_q, div_r,
        output rsp_ready,
        input  req_ready, div_start, div_a, div_b,
        input  rsp_valid, rsp_q, rsp_r, rsp_err
    );

endinterface

// File: rtl/div_req_buf.sv
// div_req_buf: one-entry valid/ready holding register for a dividend/divisor pair.
module div_req_buf #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b
);

    logic         full;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         push;
    logic         pop;

    assign in_ready  = !full;
    assign out_valid = full;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_ready && full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            full <= push || (full && !pop);
            if (push) begin
                a_q <= in_a;
                b_q <= in_b;
            end
        end
    end

endmodule

// File: rtl/div_seq.sv
// div_seq: sequences one buffered division request through an external divider
// and returns quotient, remainder and a status code, with a watchdog on the divider.
module div_seq
    import div_pkg::*;
#(
    parameter int W   = 10,
    parameter int TMO = 63
) (
    input  logic   clk,
    input  logic   rst_n,
    div_seq_if.slave bus
);

    state_t            state;
    state_t            state_n;
    logic [W-1:0]      act_a;
    logic [W-1:0]      act_b;
    logic [WD_W-1:0]   wd;
    logic              tmo;
    logic              buf_valid;
    logic              buf_pop;
    logic [W-1:0]      buf_a;
    logic [W-1:0]      buf_b;
    logic              act_ld;
    logic              wd_clr;
    logic              rsp_ld;
    logic [W-1:0]      rsp_q_n;
    logic [W-1:0]      rsp_r_n;
    err_t              rsp_err_n;
    logic [W-1:0]      rsp_q_q;
    logic [W-1:0]      rsp_r_q;
    err_t              rsp_err_q;

    div_req_buf #(.W(W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.req_valid),
        .in_ready  (bus.req_ready),
        .in_a      (bus.req_a),
        .in_b      (bus.req_b),
        .out_valid (buf_valid),
        .out_ready (buf_pop),
        .out_a     (buf_a),
        .out_b     (buf_b)
    );

    assign tmo           = wd == WD_W'(TMO);
    assign bus.div_start = state == S_ISSUE;
    assign bus.div_a     = act_a;
    assign bus.div_b     = act_b;
    assign bus.rsp_valid = state == S_RESP;
    assign bus.rsp_q     = rsp_q_q;
    assign bus.rsp_r     = rsp_r_q;
    assign bus.rsp_err   = rsp_err_q;

    // Result priority in RUN: valid result, then divider giving up, then watchdog.
    always_comb begin
        state_n   = state;
        buf_pop   = 1'b0;
        act_ld    = 1'b0;
        wd_clr    = 1'b0;
        rsp_ld    = 1'b0;
        rsp_q_n   = '0;
        rsp_r_n   = '0;
        rsp_err_n = ERR_OK;
        case (state)
            S_IDLE: begin
                if (buf_valid) begin
                    buf_pop = 1'b1;
                    if (buf_b == '0) begin
                        state_n   = S_RESP;
                        rsp_ld    = 1'b1;
                        rsp_err_n = ERR_DVZ;
                    end else begin
                        state_n = S_ISSUE;
                        act_ld  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT_BUSY;
                wd_clr  = 1'b1;
            end
            S_WAIT_BUSY: begin
                if (bus.div_busy) begin
                    state_n = S_RUN;
                end else if (tmo) begin
                    state_n   = S_RESP;
                    rsp_ld    = 1'b1;
                    rsp_err_n = ERR_TMO;
                end
            end
            S_RUN: begin
                if (bus.div_valid) begin
                    state_n = S_RESP;
                    rsp_ld  = 1'b1;
                    rsp_q_n = bus.div_q;
                    rsp_r_n = bus.div_r;
                end else if (!bus.div_busy) begin
                    state_n   = S_RESP;
                    rsp_ld    = 1'b1;
                    rsp_err_n = fail_code(bus.div_ovf, bus.div_dvz);
                end else if (tmo) begin
                    state_n   = S_RESP;
                    rsp_ld    = 1'b1;
                    rsp_err_n = ERR_TMO;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wd        <= '0;
            act_a     <= '0;
            act_b     <= '0;
            rsp_q_q   <= '0;
            rsp_r_q   <= '0;
            rsp_err_q <= ERR_OK;
        end else begin
            state <= state_n;
            if (wd_clr) wd <= '0;
            else if (state == S_WAIT_BUSY || state == S_RUN) wd <= wd + 1'b1;
            if (act_ld) begin
                act_a <= buf_a;
                act_b <= buf_b;
            end
            if (rsp_ld) begin
                rsp_q_q   <= rsp_q_n;
                rsp_r_q   <= rsp_r_n;
                rsp_err_q <= rsp_err_n;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed checks of div_seq against a small behavioural divider.
module tb_div_seq;

    localparam int W   = 10;
    localparam int TMO = 63;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   starts = 0;
    int   mode = 0;
    int   cnt;

    div_seq_if #(.W(W)) bus ();

    div_seq #(.W(W), .TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.div_start) starts <= starts + 1;

    // mode 0: result after a short run; 1: gives up with ovf; 2: never busy; 3: gives up with dvz
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.div_busy  <= 1'b0;
            bus.div_valid <= 1'b0;
            bus.div_ovf   <= 1'b0;
            bus.div_dvz   <= 1'b0;
            bus.div_q     <= '0;
            bus.div_r     <= '0;
            cnt           <= 0;
        end else begin
            bus.div_valid <= 1'b0;
            if (bus.div_start && mode != 2) begin
                bus.div_busy <= 1'b1;
                bus.div_ovf  <= 1'b0;
                bus.div_dvz  <= 1'b0;
                cnt          <= 4;
            end else if (bus.div_busy) begin
                if (cnt == 0) begin
                    bus.div_busy <= 1'b0;
                    if (mode == 0) begin
                        bus.div_valid <= 1'b1;
                        bus.div_q     <= bus.div_a / bus.div_b;
                        bus.div_r     <= bus.div_a % bus.div_b;
                    end else begin
                        bus.div_ovf <= (mode == 1);
                        bus.div_dvz <= (mode == 3);
                    end
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int n);
        n = 0;
        while (!bus.rsp_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_drop", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    int n;
    int s0;
    logic ok;
    logic [W-1:0] q0;
    logic [W-1:0] r0;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #12;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_div_start", {31'd0, bus.div_start}, 32'd0);
        check("rst_div_a", 32'(bus.div_a), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        s0 = starts;
        send(10'd100, 10'd7);
        wait_rsp(40, n);
        check("q_100_7", 32'(bus.rsp_q), 32'd14);
        check("r_100_7", 32'(bus.rsp_r), 32'd2);
        check("err_100_7", 32'(bus.rsp_err), 32'd0);
        check("one_start", 32'(starts - s0), 32'd1);
        check("div_a_held", 32'(bus.div_a), 32'd100);
        check("div_b_held", 32'(bus.div_b), 32'd7);
        repeat (3) @(negedge clk);
        check("rsp_hold", {31'd0, bus.rsp_valid}, 32'd1);
        ack();

        s0 = starts;
        send(10'd55, 10'd0);
        check("dvz_lat1", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        check("dvz_lat2", {31'd0, bus.rsp_valid}, 32'd1);
        check("dvz_err", 32'(bus.rsp_err), 32'd1);
        check("dvz_q", 32'(bus.rsp_q), 32'd0);
        check("dvz_r", 32'(bus.rsp_r), 32'd0);
        check("dvz_nostart", 32'(starts - s0), 32'd0);
        ack();

        mode = 1;
        send(10'd9, 10'd3);
        wait_rsp(40, n);
        check("ovf_err", 32'(bus.rsp_err), 32'd2);
        check("ovf_q", 32'(bus.rsp_q), 32'd0);
        ack();

        mode = 3;
        send(10'd9, 10'd3);
        wait_rsp(40, n);
        check("dvz_run_err", 32'(bus.rsp_err), 32'd1);
        ack();

        mode = 2;
        send(10'd9, 10'd3);
        wait_rsp(300, n);
        check("tmo_err", 32'(bus.rsp_err), 32'd3);
        check("tmo_lat", {31'd0, (n >= TMO + 2 && n <= TMO + 4)}, 32'd1);
        ack();

        mode = 0;
        send(10'd100, 10'd7);
        send(10'd50, 10'd6);
        check("b2b_ready_low", {31'd0, bus.req_ready}, 32'd0);
        wait_rsp(40, n);
        q0 = bus.rsp_q;
        r0 = bus.rsp_r;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_q !== q0 || bus.rsp_r !== r0) ok = 1'b0;
        end
        check("b2b_stable", {31'd0, ok}, 32'd1);
        check("b2b_q1", 32'(bus.rsp_q), 32'd14);
        check("b2b_r1", 32'(bus.rsp_r), 32'd2);
        ack();
        wait_rsp(40, n);
        check("b2b_q2", 32'(bus.rsp_q), 32'd8);
        check("b2b_r2", 32'(bus.rsp_r), 32'd2);
        check("b2b_ready_high", {31'd0, bus.req_ready}, 32'd1);
        ack();

        send(10'd100, 10'd7);
        n = 0;
        while (!bus.div_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("run_busy", {31'd0, bus.div_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_div_a", 32'(bus.div_a), 32'd0);
        check("arst_div_b", 32'(bus.div_b), 32'd0);
        check("arst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("arst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("arst_rsp_q", 32'(bus.rsp_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = starts;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.div_start) ok = 1'b0;
        end
        check("no_rsp_after_rst", {31'd0, ok}, 32'd1);
        check("no_start_after_rst", 32'(starts - s0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
